// File: rtl/dragonfang_pkg.sv
// Shared types and helpers for the vector min/max sequencer.
// Optional build macro MINMAX_SEQ_SCALAR_EN enables the .vx scalar form.
package dragonfang_pkg;

  localparam int unsigned BEAT_BYTES     = 8;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned MAX_VL_WIDTH   = 16;
  localparam int unsigned BYTE_CNT_WIDTH = MAX_VL_WIDTH + 3;
  localparam int unsigned BEAT_CNT_WIDTH = BYTE_CNT_WIDTH - 2;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef enum logic [1:0] {
    OP_MINU = 2'd0,
    OP_MIN  = 2'd1,
    OP_MAXU = 2'd2,
    OP_MAX  = 2'd3
  } minmax_op_t;

  typedef enum logic {
    SRC_VV = 1'b0,
    SRC_VX = 1'b1
  } operand_src_t;

  typedef struct packed {
    minmax_op_t   op;
    sew_t         sew;
    operand_src_t src;
  } execution_vector_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } minmax_seq_state_t;

  typedef struct packed {
    logic [BEAT_CNT_WIDTH-1:0] beats;
    logic [BEAT_BYTES-1:0]     be;
  } tail_t;

  // Beat count and last-beat byte enable for vl elements of the given SEW
  function automatic tail_t tail_be(input logic [MAX_VL_WIDTH-1:0] vl, input sew_t sew);
    logic [BYTE_CNT_WIDTH-1:0] nbytes;
    logic [2:0]                rem;
    tail_t                     t;
    nbytes  = BYTE_CNT_WIDTH'(vl) << sew;
    rem     = nbytes[2:0];
    t.beats = BEAT_CNT_WIDTH'((nbytes + BYTE_CNT_WIDTH'(7)) >> 3);
    t.be    = (rem == 3'd0) ? 8'hFF : 8'(8'hFF >> (4'd8 - {1'b0, rem}));
    return t;
  endfunction

  // Splat the low SEW bits of a scalar across a full beat
  function automatic logic [DATA_WIDTH-1:0] replicate_scalar(input logic [DATA_WIDTH-1:0] s,
                                                             input sew_t sew);
    logic [DATA_WIDTH-1:0] r;
    case (sew)
      SEW_8:   r = {8{s[7:0]}};
      SEW_16:  r = {4{s[15:0]}};
      SEW_32:  r = {2{s[31:0]}};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_minmax_unit.sv
// Combinational per-lane signed/unsigned min/max over one 64-bit beat.
module vector_minmax_unit
  import dragonfang_pkg::*;
(
  input  execution_vector_t execution_vector,
  input  logic [63:0]       vs2,
  input  logic [63:0]       vs1,
  output logic [63:0]       vd
);

  logic        sgn;
  logic        mx;
  logic [63:0] t;
  logic        unused_src;

  assign sgn        = (execution_vector.op == OP_MIN) || (execution_vector.op == OP_MAX);
  assign mx         = (execution_vector.op == OP_MAX) || (execution_vector.op == OP_MAXU);
  assign unused_src = execution_vector.src;

  // Lanes are top-aligned so one 65-bit signed compare serves every width
  function automatic logic [63:0] lane_op(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w, input logic is_signed,
                                          input logic is_max);
    logic [63:0]        at;
    logic [63:0]        bt;
    logic signed [64:0] ka;
    logic signed [64:0] kb;
    logic               a_gt_b;
    at     = a << (64 - w);
    bt     = b << (64 - w);
    ka     = {is_signed & at[63], at};
    kb     = {is_signed & bt[63], bt};
    a_gt_b = ka > kb;
    return (is_max == a_gt_b) ? a : b;
  endfunction

  // Per-SEW lane split and select
  always_comb begin
    vd = '0;
    t  = '0;
    case (execution_vector.sew)
      SEW_8: begin
        for (int i = 0; i < 8; i++) begin
          t = lane_op(64'(vs2[i*8 +: 8]), 64'(vs1[i*8 +: 8]), 8, sgn, mx);
          vd[i*8 +: 8] = t[7:0];
        end
      end
      SEW_16: begin
        for (int i = 0; i < 4; i++) begin
          t = lane_op(64'(vs2[i*16 +: 16]), 64'(vs1[i*16 +: 16]), 16, sgn, mx);
          vd[i*16 +: 16] = t[15:0];
        end
      end
      SEW_32: begin
        for (int i = 0; i < 2; i++) begin
          t = lane_op(64'(vs2[i*32 +: 32]), 64'(vs1[i*32 +: 32]), 32, sgn, mx);
          vd[i*32 +: 32] = t[31:0];
        end
      end
      default: vd = lane_op(vs2, vs1, 64, sgn, mx);
    endcase
  end

endmodule

// File: rtl/vector_minmax_sequencer.sv
// Steps one vector min/max command through the VRF a beat at a time:
// read operands, run the lane unit, write the result with a tail byte enable.
// Build macro MINMAX_SEQ_SCALAR_EN adds cmd_scalar and the .vx operand form.
module vector_minmax_sequencer
  import dragonfang_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned VL_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  execution_vector_t     cmd_execution_vector,
  input  logic [1:0]            cmd_sew,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_vd_addr,
`ifdef MINMAX_SEQ_SCALAR_EN
  input  logic [63:0]           cmd_scalar,
`endif
  output logic                  vrf_rd_en,
  output logic [ADDR_WIDTH-1:0] vrf_rd_addr2,
  output logic [ADDR_WIDTH-1:0] vrf_rd_addr1,
  input  logic [63:0]           vrf_rd_data2,
  input  logic [63:0]           vrf_rd_data1,
  output logic                  vrf_wr_en,
  output logic [ADDR_WIDTH-1:0] vrf_wr_addr,
  output logic [63:0]           vrf_wr_data,
  output logic [7:0]            vrf_wr_be,
  output logic                  busy,
  output logic                  done
);

  minmax_seq_state_t         state;
  execution_vector_t         ev_q;
  logic [ADDR_WIDTH-1:0]     vs2_base;
  logic [ADDR_WIDTH-1:0]     vs1_base;
  logic [ADDR_WIDTH-1:0]     vd_base;
  logic [BEAT_CNT_WIDTH-1:0] beat;
  logic [BEAT_CNT_WIDTH-1:0] next_beat;
  logic [BEAT_CNT_WIDTH-1:0] last_beat;
  logic [7:0]                last_be;
  tail_t                     cmd_tail;
  logic                      cmd_vx;
  logic                      vx_mode;
  logic [63:0]               unit_vs1;
  logic [63:0]               unit_vd;

`ifdef MINMAX_SEQ_SCALAR_EN
  logic        vx_q;
  logic [63:0] scalar_q;
  sew_t        sew_q;
  assign cmd_vx  = (cmd_execution_vector.src == SRC_VX);
  assign vx_mode = vx_q;
`else
  assign cmd_vx  = 1'b0;
  assign vx_mode = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign next_beat = beat + 1'b1;

  // Length decode of the incoming command
  always_comb begin
    cmd_tail = tail_be(MAX_VL_WIDTH'(cmd_vl), sew_t'(cmd_sew));
  end

  // Second operand: VRF data, or the splatted scalar in .vx mode
  always_comb begin
    unit_vs1 = vrf_rd_data1;
`ifdef MINMAX_SEQ_SCALAR_EN
    if (vx_q) unit_vs1 = replicate_scalar(scalar_q, sew_q);
`endif
  end

  vector_minmax_unit u_unit (
    .execution_vector (ev_q),
    .vs2              (vrf_rd_data2),
    .vs1              (unit_vs1),
    .vd               (unit_vd)
  );

  // Sequencer FSM with registered VRF strobes and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ev_q         <= '0;
      vs2_base     <= '0;
      vs1_base     <= '0;
      vd_base      <= '0;
      beat         <= '0;
      last_beat    <= '0;
      last_be      <= '0;
`ifdef MINMAX_SEQ_SCALAR_EN
      vx_q         <= 1'b0;
      scalar_q     <= '0;
      sew_q        <= SEW_8;
`endif
      vrf_rd_en    <= 1'b0;
      vrf_rd_addr2 <= '0;
      vrf_rd_addr1 <= '0;
      vrf_wr_en    <= 1'b0;
      vrf_wr_addr  <= '0;
      vrf_wr_data  <= '0;
      vrf_wr_be    <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            ev_q      <= cmd_execution_vector;
            vs2_base  <= cmd_vs2_addr;
            vs1_base  <= cmd_vs1_addr;
            vd_base   <= cmd_vd_addr;
            beat      <= '0;
            last_beat <= cmd_tail.beats - 1'b1;
            last_be   <= cmd_tail.be;
`ifdef MINMAX_SEQ_SCALAR_EN
            vx_q      <= cmd_vx;
            scalar_q  <= cmd_scalar;
            sew_q     <= sew_t'(cmd_sew);
`endif
            if (cmd_tail.beats == '0) begin
              done <= 1'b1;
            end else begin
              state        <= ST_READ;
              vrf_rd_en    <= 1'b1;
              vrf_rd_addr2 <= cmd_vs2_addr;
              vrf_rd_addr1 <= cmd_vx ? '0 : cmd_vs1_addr;
            end
          end
        end
        ST_READ: begin
          vrf_rd_en <= 1'b0;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          vrf_wr_en   <= 1'b1;
          vrf_wr_addr <= vd_base + ADDR_WIDTH'(beat);
          vrf_wr_data <= unit_vd;
          vrf_wr_be   <= (beat == last_beat) ? last_be : 8'hFF;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          vrf_wr_en <= 1'b0;
          if (beat == last_beat) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            beat         <= next_beat;
            state        <= ST_READ;
            vrf_rd_en    <= 1'b1;
            vrf_rd_addr2 <= vs2_base + ADDR_WIDTH'(next_beat);
            vrf_rd_addr1 <= vx_mode ? '0 : vs1_base + ADDR_WIDTH'(next_beat);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_minmax_sequencer.md
# vector_minmax_sequencer

Sequences a single vector min/max instruction over a full vector length. It accepts one command, reads operand beats from the vector register file (VRF), and drives them through the combinational `vector_minmax_unit` one 64-bit beat at a time. It writes each result beat back to the VRF with a tail byte-enable on the last beat. It sits between the vector issue stage and the VRF read/write ports.

## Interface
- `ADDR_WIDTH`, 5, VRF beat-address width.
- `VL_WIDTH`, 9, width of vl in elements.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_execution_vector` in `execution_vector_t`: min/max operation and SEW control for the unit.
- `cmd_sew` in 2: 0=8, 1=16, 2=32, 3=64 bits.
- `cmd_vl` in VL_WIDTH: element count.
- `cmd_vs2_addr`, `cmd_vs1_addr`, `cmd_vd_addr` in ADDR_WIDTH: base beat addresses.
- `cmd_scalar` in 64: scalar operand; present only with the macro.
- `vrf_rd_en` out 1; `vrf_rd_addr2`, `vrf_rd_addr1` out ADDR_WIDTH.
- `vrf_rd_data2`, `vrf_rd_data1` in 64: valid the cycle after `vrf_rd_en`.
- `vrf_wr_en` out 1; `vrf_wr_addr` out ADDR_WIDTH; `vrf_wr_data` out 64; `vrf_wr_be` out 8.
- `busy` out 1; `done` out 1: single-cycle pulse.

## Operation
- States: IDLE, READ, EXEC, WRITE.
- `cmd_ready` = (state == IDLE). Accept occurs on `cmd_valid && cmd_ready`; all command fields are registered at accept.
- Byte count: `bytes = cmd_vl << cmd_sew`.
- Beat count: `beats = ceil(bytes/8)`.
- Last-beat byte enable: `be = (bytes%8 == 0) ? 8'hFF : (8'hFF >> (8 - bytes%8))`. All other beats use 8'hFF.
- IDLE→READ on accept with `beats > 0`. If `vl == 0`, stay in IDLE: no VRF traffic, and `done` pulses the next cycle.
- READ:
  - `vrf_rd_en = 1`.
  - Read addresses are base + beat index, modulo 2^ADDR_WIDTH (wrap-around is silent).
  - Go to EXEC.
- EXEC: read data feeds the unit; the unit's `vd` is captured into the result register. Go to WRITE.
- WRITE:
  - `vrf_wr_en = 1`; `vrf_wr_addr = vd_base + beat`; `vrf_wr_data` = result register; `vrf_wr_be` per the rule above.
  - If this is the last beat, go to IDLE and pulse `done`. Otherwise increment the beat index and go to READ.
- `busy` = (state != IDLE).
- `cmd_valid` while busy has no effect.
- Reset mid-operation:
  - State returns to IDLE immediately.
  - Strobes drop asynchronously.
  - The command is discarded; already-written beats are not undone.
- Reset values: `cmd_ready = 1`. `busy`, `done`, `vrf_rd_en`, `vrf_wr_en` = 0. All addresses, `vrf_wr_data` and `vrf_wr_be` = 0.

## Timing
- Accept at cycle T0.
- Beat k (0-based):
  - READ at T0 + 1 + 3k.
  - EXEC at T0 + 2 + 3k.
  - WRITE at T0 + 3 + 3k.
- Last write at T0 + 3·beats.
- `done` and `cmd_ready` are both 1 at T0 + 3·beats + 1, so a back-to-back command can be accepted in that cycle.
- `vl == 0`: `done` at T0 + 1, `cmd_ready` stays 1.
- All outputs are registered except `cmd_ready` and `busy`, which decode the state register.

## Configuration
- `MINMAX_SEQ_SCALAR_EN` defined:
  - Adds the `cmd_scalar` port and the `.vx` form, selected by `execution_vector` operand-source field.
  - The registered scalar is replicated across the beat per SEW (8×8, 4×16, 2×32, 1×64 bits) and replaces `vrf_rd_data1`.
  - `vrf_rd_addr1` is driven 0 in `.vx` mode.
- Undefined: the port is absent; only `.vv` is supported; the operand-source field is ignored.

## Structure
- `dragonfang_pkg` holds:
  - `execution_vector_t`.
  - A `sew_t` enum (SEW_8..SEW_64).
  - A `minmax_seq_state_t` enum.
  - The `BEAT_BYTES = 8` constant.
- Single sub-module: one instance of the existing `vector_minmax_unit` (ports `execution_vector`, `vs2`, `vs1`, `vd`).
- The byte-enable/beat-count math lives in a package function, `tail_be()`.

## Test plan
- vmax_8, vl=3, vs2=0x..._7F_80_01, vs1=0x..._00_00_02 → one write, `be = 8'h07`, low bytes = 0x7F_00_02, `done` at T0+4.
- vminu_32, vl=10, bases vs2=4, vs1=12, vd=20 → 5 writes to addresses 20..24, all `be = 8'hFF`, `done` at T0+16.
- vmin_16, vl=9 → 3 beats, last `be = 8'h03`; each lane matches a signed 16-bit min of the VRF contents.
- vl=0 → no `rd_en`/`wr_en`, `done` at T0+1, a second command accepted at T0+1.
- Reset asserted in EXEC of beat 2 of a 4-beat op → outputs idle in the same cycle, no further writes, `cmd_ready = 1` after release.
- (`MINMAX_SEQ_SCALAR_EN`) vmaxu_8 `.vx`, scalar=0x40, vs2 beat=0x10_FF_40_3F... → result bytes 0x40_FF_40_40.
